// File: rtl/jtag_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master_pkg
// Description : Shared types and constants for the jtag_master initiator:
//               command opcodes, FSM state encoding, TMS preamble/postamble
//               lengths and patterns (bit i = TMS value of TCK i).
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_IR_SCAN   = 2'd1,
        OP_DR_SCAN   = 2'd2,
        OP_IDLE      = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PRE   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_POST  = 3'd4,
        ST_RESP  = 3'd5
    } jtag_state_e;

    localparam logic [6:0] c_PRE_LEN_DR    = 7'd3;
    localparam logic [6:0] c_PRE_LEN_IR    = 7'd4;
    localparam logic [6:0] c_PRE_LEN_POST  = 7'd2;
    localparam logic [6:0] c_PRE_LEN_RESET = 7'd6;

    // RTI -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [7:0] c_TMS_DR    = 8'b0000_0001;
    // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [7:0] c_TMS_IR    = 8'b0000_0011;
    // Five ones reach Test-Logic-Reset from anywhere, then a zero into RTI
    localparam logic [7:0] c_TMS_RESET = 8'b0001_1111;
    // Exit1 -> Update -> RTI
    localparam logic [7:0] c_TMS_POST  = 8'b0000_0001;

    function automatic logic [6:0] pre_len(input jtag_op_e op);
        case (op)
            OP_IR_SCAN: return c_PRE_LEN_IR;
            OP_DR_SCAN: return c_PRE_LEN_DR;
            default:    return c_PRE_LEN_RESET;
        endcase
    endfunction

    function automatic logic pre_tms(input jtag_op_e op, input logic [2:0] idx);
        logic [7:0] pat;
        case (op)
            OP_IR_SCAN: pat = c_TMS_IR;
            OP_DR_SCAN: pat = c_TMS_DR;
            default:    pat = c_TMS_RESET;
        endcase
        return pat[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tck_gen
// Description : TCK divider. While en_i is high it produces TCK periods of
//               2*CLK_DIV clocks (low phase first). fall_stb_o marks a cycle
//               whose closing edge starts a TCK period (update TMS/TDI);
//               rise_end_stb_o marks a cycle whose closing edge ends a high
//               phase (sample TDO, advance bit). The first cycle after enable
//               is a launch cycle that only raises fall_stb_o.
// Revision    : 1.0 - initial release
// Ports       : clk_i, rst_i       clock, synchronous active-high reset
//               en_i               run request from the sequencer FSM
//               tck_o              registered TCK, 0 when idle
//               fall_stb_o         start-of-TCK strobe
//               rise_end_stb_o     end-of-high-phase strobe
// ============================================================================
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tck_o,
    output logic fall_stb_o,
    output logic rise_end_stb_o
);

    localparam int c_CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(2 * CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLK_DIV);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               run_q;
    logic               tck_q, tck_d;
    logic               w_wrap;

    assign w_wrap = run_q && (cnt_q == c_LAST);

    always_comb begin
        cnt_d = '0;
        tck_d = 1'b0;
        if (en_i && run_q && !w_wrap) begin
            cnt_d = cnt_q + 1'b1;
            tck_d = (cnt_d >= c_HALF);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= en_i;
            tck_q <= tck_d;
        end
    end

    assign tck_o          = tck_q;
    assign fall_stb_o     = en_i && (!run_q || w_wrap);
    assign rise_end_stb_o = en_i && w_wrap;

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master
// Description : JTAG initiator. Runs TAP_RESET / IR_SCAN / DR_SCAN / IDLE
//               commands from a valid/ready request channel and returns the
//               captured TDO bits on a valid/ready response channel. An
//               automatic TAP reset runs after every reset release.
// Revision    : 1.0 - initial release
// Config      : JTAG_MASTER_TRST_EN adds active-low trst_no output.
// Ports       : clk_i, rst_i                  clock, sync active-high reset
//               cmd_valid_i/cmd_ready_o       command handshake
//               cmd_op_i/len_i/data_i         opcode, bits-1, TDI data
//               rsp_valid_o/rsp_ready_i       response handshake
//               rsp_data_o                    captured TDO, LSB first
//               tck_o, tms_o, tdi_o, tdo_i    JTAG pins
//               trst_no                       optional TAP reset (active low)
// ============================================================================
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [63:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
`ifdef JTAG_MASTER_TRST_EN
    ,
    output logic        trst_no
`endif
);

    jtag_state_e state_q, state_d;
    jtag_op_e    op_q, op_d;
    logic [5:0]  len_q, len_d;
    logic [63:0] data_q, data_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    logic w_en;
    logic w_fall;
    logic w_rise;

    assign w_en = (state_q == ST_INIT) || (state_q == ST_PRE) ||
                  (state_q == ST_SHIFT) || (state_q == ST_POST);

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (w_en),
        .tck_o          (tck_o),
        .fall_stb_o     (w_fall),
        .rise_end_stb_o (w_rise)
    );

    // state_d/cnt_d name the TCK that the next fall strobe launches. On the
    // launch cycle (no rise strobe) they equal the current values, so the
    // first TCK of a sequence uses the same pin-drive decode as the rest.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d       = jtag_op_e'(cmd_op_i);
                    len_d      = cmd_len_i;
                    data_d     = cmd_data_i;
                    rsp_data_d = '0;
                    cnt_d      = '0;
                    state_d    = (jtag_op_e'(cmd_op_i) == OP_IDLE) ? ST_SHIFT : ST_PRE;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (w_rise) begin
                    if (cnt_q == c_PRE_LEN_RESET - 7'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_PRE: begin
                if (w_rise) begin
                    if (cnt_q == pre_len(op_q) - 7'd1) begin
                        cnt_d   = '0;
                        state_d = (op_q == OP_TAP_RESET) ? ST_RESP : ST_SHIFT;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    if (op_q != OP_IDLE) begin
                        rsp_data_d[cnt_q[5:0]] = tdo_i;
                    end
                    if (cnt_q == {1'b0, len_q}) begin
                        cnt_d   = '0;
                        state_d = (op_q == OP_IDLE) ? ST_RESP : ST_POST;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_POST: begin
                if (w_rise) begin
                    if (cnt_q == c_PRE_LEN_POST - 7'd1) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Pin drive for the TCK starting at this edge; TMS holds its last
        // value once the sequence ends (TAP parked in RTI).
        if (w_fall) begin
            tdi_d = 1'b0;
            case (state_d)
                ST_INIT:  tms_d = c_TMS_RESET[cnt_d[2:0]];
                ST_PRE:   tms_d = pre_tms(op_q, cnt_d[2:0]);
                ST_SHIFT: begin
                    if (op_q == OP_IDLE) begin
                        tms_d = 1'b0;
                    end else begin
                        tms_d = (cnt_d == {1'b0, len_q});
                        tdi_d = data_q[cnt_d[5:0]];
                    end
                end
                ST_POST:  tms_d = c_TMS_POST[cnt_d[2:0]];
                default:  tms_d = tms_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            op_q       <= OP_TAP_RESET;
            len_q      <= '0;
            data_q     <= '0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

`ifdef JTAG_MASTER_TRST_EN
    logic trst_q, trst_d;

    // Low for the first TCK of every TAP reset sequence, including INIT.
    always_comb begin
        trst_d = trst_q;
        if (w_fall) begin
            trst_d = 1'b1;
            if ((cnt_d == 7'd0) &&
                ((state_d == ST_INIT) || ((state_d == ST_PRE) && (op_q == OP_TAP_RESET)))) begin
                trst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trst_q <= 1'b0;
        end else begin
            trst_q <= trst_d;
        end
    end

    // Gated by rst_i so TRST asserts in the same cycle reset is applied.
    assign trst_no = trst_q & ~rst_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_master
// Description : Directed self-checking bench for jtag_master (CLK_DIV = 2).
//               TDO loops back TDI unless tdo_force is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_master;

    localparam int CLK_DIV = 2;

`ifdef JTAG_MASTER_TRST_EN
    localparam logic       c_TRST_RST = 1'b0;
    localparam logic [5:0] c_TRST_PAT = 6'b111110;
`else
    localparam logic       c_TRST_RST = 1'b1;
    localparam logic [5:0] c_TRST_PAT = 6'b111111;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic        tdo_force = 1'b0;
    logic        trst_mon;

    assign tdo = tdo_force ? 1'b1 : tdi;

    always #5 clk = ~clk;

    jtag_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
`ifdef JTAG_MASTER_TRST_EN
        ,
        .trst_no     (trst_mon)
`endif
    );

`ifndef JTAG_MASTER_TRST_EN
    assign trst_mon = 1'b1;
`endif

    // Pin recorder: one entry per TCK rising edge.
    int   tck_cnt = 0;
    logic tms_rec  [0:1023];
    logic tdi_rec  [0:1023];
    logic trst_rec [0:1023];

    always @(posedge tck) begin
        if (tck_cnt < 1024) begin
            tms_rec[tck_cnt]  = tms;
            tdi_rec[tck_cnt]  = tdi;
            trst_rec[tck_cnt] = trst_mon;
        end
        tck_cnt = tck_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = TMS, 1 = TDI, 2 = TRST
    function automatic logic [127:0] pack(input int sel, input int base, input int n);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       v[i] = tms_rec[base + i];
                1:       v[i] = tdi_rec[base + i];
                default: v[i] = trst_rec[base + i];
            endcase
        end
        return v;
    endfunction

    task automatic reset_init;
        int n = 0;
        int b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pins", {tck, tms, tdi, cmd_ready, rsp_valid, trst_mon},
              {5'b01000, c_TRST_RST});
        check("rst_rsp_data", rsp_data, 64'd0);
        b   = tck_cnt;
        rst = 1'b0;
        while (cmd_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("init_ready", cmd_ready, 1'b1);
        check("init_ntck", tck_cnt - b, 6);
        check("init_tms", pack(0, b, 6), 6'b011111);
        check("init_trst", pack(2, b, 6), c_TRST_PAT);
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [5:0] len,
                             input logic [63:0] data, output int base);
        int n = 0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", cmd_ready, 1'b1);
        base = tck_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 64'd0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic ack_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_state", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int          b;
        int          lat;
        int          n;
        logic [63:0] d64;

        d64 = 64'hDEADBEEF_CAFEF00D;
        reset_init();

        // IR scan, 5 bits of 0x01: 11 TCK, valid at clock 45
        issue_cmd(2'd1, 6'd4, 64'h01, b);
        wait_rsp(lat);
        check("ir_lat", lat, 45);
        check("ir_ntck", tck_cnt - b, 11);
        check("ir_tms", pack(0, b, 11), 11'h303);
        check("ir_tdi", pack(1, b, 11), 11'h010);
        check("ir_rsp", rsp_data, 64'h01);
        ack_rsp();

        // 64-bit DR scan with loopback, then backpressure
        issue_cmd(2'd2, 6'd63, d64, b);
        wait_rsp(lat);
        check("dr64_lat", lat, 277);
        check("dr64_tms", pack(0, b, 69), (128'd1 << 0) | (128'd1 << 66) | (128'd1 << 67));
        check("dr64_tdi", pack(1, b + 3, 64), d64);
        check("dr64_rsp", rsp_data, d64);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_ctrl", {rsp_valid, cmd_ready, tck}, 3'b100);
            check("bp_data", rsp_data, d64);
        end
        check("bp_ntck", tck_cnt - b, 69);
        ack_rsp();

        // 8-bit DR scan with TDO tied high: upper bits stay zero
        tdo_force = 1'b1;
        issue_cmd(2'd2, 6'd7, 64'h5A, b);
        wait_rsp(lat);
        check("dr8_lat", lat, 53);
        check("dr8_rsp", rsp_data, 64'hFF);
        check("dr8_tdi", pack(1, b, 13), 13'b0_0010_1101_0000);
        ack_rsp();
        tdo_force = 1'b0;

        // IDLE, 10 TCK in RTI
        issue_cmd(2'd3, 6'd9, 64'hFFFF, b);
        wait_rsp(lat);
        check("idle_lat", lat, 41);
        check("idle_ntck", tck_cnt - b, 10);
        check("idle_tms", pack(0, b, 10), 10'd0);
        check("idle_tdi", pack(1, b, 10), 10'd0);
        check("idle_rsp", rsp_data, 64'd0);
        ack_rsp();

        // TAP_RESET command
        issue_cmd(2'd0, 6'd0, 64'hFFFF, b);
        wait_rsp(lat);
        check("trst_cmd_lat", lat, 25);
        check("trst_cmd_ntck", tck_cnt - b, 6);
        check("trst_cmd_tms", pack(0, b, 6), 6'b011111);
        check("trst_cmd_trst", pack(2, b, 6), c_TRST_PAT);
        check("trst_cmd_rsp", rsp_data, 64'd0);
        ack_rsp();

        // Reset during shift bit 10 of a DR scan
        issue_cmd(2'd2, 6'd63, d64, b);
        n = 0;
        while ((tck_cnt - b) < 14 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", tck_cnt - b, 14);
        check("mid_pins", {tms, tdi}, {1'b0, d64[10]});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pins", {tck, tms, tdi, rsp_valid, cmd_ready}, 5'b01000);
        check("mid_rst_data", rsp_data, 64'd0);
        reset_init();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
